// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the single-outstanding APB initiator.
// Holds the FSM state encoding, the error read-data pattern and a clog2 helper.
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [31:0] APB_ERR_RDATA = 32'hFFFF_FFFF;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request to APB SETUP/ACCESS bridge with address decode,
// PREADY wait states and a bounded ACCESS phase that returns an error on expiry.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int NSEL       = 4,
    parameter int SLV_ADDR_W = 4,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [NSEL-1:0]       PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [SLV_ADDR_W-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic [NSEL*32-1:0]    PRDATA,
    input  logic [NSEL-1:0]       PREADY
);

    localparam int SEL_W = ADDR_W - SLV_ADDR_W;
    localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [NSEL-1:0]    sel_onehot;
    logic [31:0]        prdata_mask [NSEL];
    logic [31:0]        prdata_sel;
    logic               pready_sel;
    logic               timeout_hit;
    logic [SEL_W-1:0]   req_sel;
    logic               req_sel_ok;
    logic               req_fire;

    assign req_sel    = req_addr[ADDR_W-1:SLV_ADDR_W];
    assign req_sel_ok = (32'(req_sel) < 32'(NSEL));
    assign req_fire   = req_valid && (state_reg == ST_IDLE);

    // Decode and read mux work off the latched select, so a stale PREADY or
    // PRDATA from an unselected completer can never reach the response.
    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_slot
            assign sel_onehot[gi]  = (sel_reg == SEL_W'(gi));
            assign prdata_mask[gi] = sel_onehot[gi] ? PRDATA[32*gi +: 32] : 32'd0;
        end
    endgenerate

    always_comb begin
        prdata_sel = 32'd0;
        for (int i = 0; i < NSEL; i++) begin
            prdata_sel = prdata_sel | prdata_mask[i];
        end
    end

    assign pready_sel = |(PREADY & sel_onehot);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) && !pready_sel;
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        PSEL       = '0;
        PENABLE    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_sel_ok ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                PSEL       = sel_onehot;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = sel_onehot;
                PENABLE = 1'b1;
                if (pready_sel || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus fields are captured only on accept, so they hold while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_reg      <= '0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= 32'd0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            if (req_fire) begin
                sel_reg <= req_sel;
                PWRITE  <= req_write;
                PADDR   <= req_addr[SLV_ADDR_W-1:0];
                PWDATA  <= req_wdata;
                if (!req_sel_ok) begin
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b1;
                end
            end

            if (state_reg == ST_SETUP) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == ST_ACCESS && !pready_sel && wait_cnt_reg != CNT_MAX) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end

            if (state_reg == ST_ACCESS) begin
                if (pready_sel) begin
                    resp_rdata <= PWRITE ? 32'd0 : prdata_sel;
                    resp_err   <= 1'b0;
                end else if (timeout_hit) begin
                    resp_rdata <= APB_ERR_RDATA;
                    resp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator. Converts a valid/ready request/response interface from a CPU or debug agent into APB SETUP/ACCESS transfers.
- Decodes the request address into one of NSEL peripheral selects; peripherals such as apb_uart sit on those selects.
- Supports PREADY wait states, which peripherals may or may not use.
- Bounds every transfer with a timeout, so a hung peripheral returns an error instead of stalling the requester.

Parameters:
- NSEL, 4: number of APB completers, one PSEL bit each.
- SLV_ADDR_W, 4: PADDR width; the low req_addr bits are forwarded.
- ADDR_W, 8: req_addr width. The select index is req_addr[ADDR_W-1:SLV_ADDR_W].
- TIMEOUT, 256: maximum ACCESS cycles before an error response. 0 disables the timeout.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset. Asserted (0) forces reset state immediately; release is synchronous to clk.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts a request this cycle.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  write data.
- resp_valid  out  1  response available; held until consumed.
- resp_ready  in  1  requester consumes response.
- resp_rdata  out  32  read data, 0 for writes.
- resp_err  out  1  decode error or timeout.
- PSEL  out  NSEL  one-hot completer select.
- PENABLE  out  1  ACCESS phase.
- PWRITE  out  1  transfer direction.
- PADDR  out  SLV_ADDR_W  completer address.
- PWDATA  out  32  write data.
- PRDATA  in  NSEL*32  per-completer read data, packed; slice i = [32i+31:32i].
- PREADY  in  NSEL  per-completer ready.

Behaviour:
- States and outputs:
  - IDLE: req_ready=1, bus idle.
  - SETUP: PSEL[sel]=1, PENABLE=0.
  - ACCESS: PSEL[sel]=1, PENABLE=1.
  - RESP: resp_valid=1.
- req_ready is combinational (state==IDLE); no other state accepts a request.
- IDLE, req_valid=1: latch write, addr, wdata and sel=req_addr[ADDR_W-1:SLV_ADDR_W].
  - sel>=NSEL: go to RESP with resp_err=1, resp_rdata=0. No bus cycle is issued.
  - Otherwise: go to SETUP.
- SETUP: always goes to ACCESS next cycle. PADDR, PWRITE and PWDATA are driven from latched values and stay stable through SETUP and ACCESS.
- ACCESS: PREADY[sel] sampled high at a clock edge completes the transfer.
  - Read: resp_rdata=PRDATA slice sel.
  - Write: resp_rdata=0.
  - resp_err=0; go to RESP. PSEL and PENABLE deassert on that same edge.
- Wait counter (TIMEOUT>0):
  - Cleared on entry to ACCESS; increments each ACCESS cycle with PREADY[sel]=0.
  - If count==TIMEOUT-1 and PREADY[sel]=0: abort to RESP with resp_err=1, resp_rdata=32'hFFFF_FFFF; PSEL/PENABLE drop.
  - PREADY high on the deadline cycle wins: normal completion.
  - Counter width is clog2(TIMEOUT+1); it never wraps.
- RESP: resp_valid=1 with resp_rdata/resp_err stable until resp_ready=1, then IDLE. resp_valid may stay high indefinitely; the bus stays idle meanwhile.
- Latency, zero wait states: accept at edge N; SETUP in cycle N+1; ACCESS in N+2; resp_valid high from N+3. Next accept is possible one cycle after the resp handshake, giving 4-cycle minimum throughput.
- PREADY of unselected completers is ignored. PSEL is never multi-hot, and PENABLE is never high without PSEL.
- Bus address/data outputs hold their last values while idle.
- Reset values: state=IDLE, so req_ready=1. PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronously) and any pending response is discarded.

Decomposition:
- Shared package:
  - state encoding (IDLE, SETUP, ACCESS, RESP, 2 bits);
  - APB_ERR_RDATA=32'hFFFF_FFFF;
  - clog2 helper function.
- No sub-module. Select decode and PRDATA mux are inline combinational logic in the one module.

Test Plan:
- Write addr 8'h14, wdata 32'h41, completer 1 ready immediately -> PSEL=4'b0010, PENABLE low then high, PADDR=4'h4, PWDATA=32'h41; resp_valid at N+3 with err=0, rdata=0.
- Read addr 8'h08, completer 0 holds PREADY low 3 ACCESS cycles then returns 32'h0000_0003 -> ACCESS lasts 4 cycles with PADDR stable; resp_rdata=32'h3, err=0.
- TIMEOUT=8, completer 2 never ready -> exactly 8 ACCESS cycles; resp_err=1, resp_rdata=32'hFFFF_FFFF; PSEL cleared.
- NSEL=4, addr 8'h5C -> no PSEL bit ever set; resp next cycle after accept with err=1, rdata=0.
- resp_ready held low 10 cycles, req_valid high -> req_ready=0 and bus idle throughout; data stable; next request accepted the cycle after the handshake.
- reset asserted during ACCESS -> PSEL/PENABLE/resp_valid 0 without a clock edge; after release a fresh read completes normally.
